reg_alu_ctrl: RTL and testbench



---
 rtl/reg_alu_ctrl_pkg.sv | 31 +++
 rtl/reg_alu_ctrl_dec.sv | 24 ++
 rtl/reg_alu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_reg_alu_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_alu_ctrl_pkg.sv
// Shared encodings for the register-file/ALU sequencer: instruction kinds,
// instruction field positions, FSM states and default datapath widths.
package reg_alu_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int OP_W_DEF   = 2;
  localparam int INSTR_W    = 16;

  localparam int KIND_LO = 14;
  localparam int OP_LO   = 12;
  localparam int DST_LO  = 9;
  localparam int SRCA_LO = 6;
  localparam int SRCB_LO = 3;
  localparam int RSVD_HI = 2;

  typedef enum logic [1:0] {
    KIND_NOP = 2'b00,
    KIND_LDI = 2'b01,
    KIND_ALU = 2'b10,
    KIND_RD  = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    FIN  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/reg_alu_ctrl_dec.sv
// Combinational field decode of the latched instruction word.
module reg_alu_ctrl_dec
  import reg_alu_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [1:0]         kind_o,
  output logic [OP_W-1:0]    op_o,
  output logic [ADDR_W-1:0]  dst_o,
  output logic [ADDR_W-1:0]  srca_o,
  output logic [ADDR_W-1:0]  srcb_o,
  output logic               reserved_err_o
);

  assign kind_o         = instr_i[KIND_LO +: 2];
  assign op_o           = instr_i[OP_LO +: OP_W];
  assign dst_o          = instr_i[DST_LO +: ADDR_W];
  assign srca_o         = instr_i[SRCA_LO +: ADDR_W];
  assign srcb_o         = instr_i[SRCB_LO +: ADDR_W];
  assign reserved_err_o = |instr_i[RSVD_HI:0];

endmodule

// File: rtl/reg_alu_ctrl.sv
// Instruction sequencer for the register-file/ALU datapath: IDLE->EXEC->(FIN)->DONE.
// Optional macro REG_ALU_CTRL_R0_ZERO_EN makes register 0 read-only.
module reg_alu_ctrl
  import reg_alu_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  imm,
  output logic               sel,
  output logic               wr,
  output logic [OP_W-1:0]    op,
  output logic [ADDR_W-1:0]  rd_addr_a,
  output logic [ADDR_W-1:0]  rd_addr_b,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  d_in,
  input  logic [DATA_W-1:0]  rd_data,
  input  logic               cout_in,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               flag,
  output logic               err
);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   imm_q;
  logic                sel_q, sel_d;
  logic                wr_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_W-1:0]   rd_addr_b_q, rd_addr_b_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   d_in_q, d_in_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                flag_q, flag_d;
  logic                err_q, err_d;

  logic [1:0]          dec_kind;
  logic [OP_W-1:0]     dec_op;
  logic [ADDR_W-1:0]   dec_dst, dec_srca, dec_srcb;
  logic                dec_rsvd_err;
  logic                r0_blk;

  reg_alu_ctrl_dec #(
    .ADDR_W (ADDR_W),
    .OP_W   (OP_W)
  ) u_dec (
    .instr_i        (instr_q),
    .kind_o         (dec_kind),
    .op_o           (dec_op),
    .dst_o          (dec_dst),
    .srca_o         (dec_srca),
    .srcb_o         (dec_srcb),
    .reserved_err_o (dec_rsvd_err)
  );

`ifdef REG_ALU_CTRL_R0_ZERO_EN
  assign r0_blk = ((kind_e'(dec_kind) == KIND_LDI) || (kind_e'(dec_kind) == KIND_ALU))
                  && (dec_dst == '0);
`else
  assign r0_blk = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wr_d        = 1'b0;
    op_d        = op_q;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    wr_addr_d   = wr_addr_q;
    d_in_d      = d_in_q;
    result_d    = result_q;
    flag_d      = flag_q;
    err_d       = err_q;
    case (state_q)
      IDLE: if (instr_valid) state_d = EXEC;
      EXEC: begin
        state_d  = DONE;
        result_d = '0;
        err_d    = dec_rsvd_err | r0_blk;
        // A malformed word executes as NOP regardless of its kind field.
        if (!dec_rsvd_err) begin
          case (kind_e'(dec_kind))
            KIND_LDI: begin
              sel_d     = 1'b0;
              wr_d      = ~r0_blk;
              d_in_d    = imm_q;
              wr_addr_d = dec_dst;
            end
            KIND_ALU: begin
              sel_d       = 1'b1;
              wr_d        = ~r0_blk;
              op_d        = dec_op;
              rd_addr_a_d = dec_srca;
              rd_addr_b_d = dec_srcb;
              wr_addr_d   = dec_dst;
              state_d     = FIN;
            end
            KIND_RD: begin
              rd_addr_a_d = dec_srca;
              result_d    = rd_data;
            end
            default: ;
          endcase
        end
      end
      FIN: begin
        flag_d  = cout_in;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      imm_q       <= '0;
      sel_q       <= 1'b0;
      op_q        <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      wr_addr_q   <= '0;
      d_in_q      <= '0;
      result_q    <= '0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      op_q        <= op_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      wr_addr_q   <= wr_addr_d;
      d_in_q      <= d_in_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
      if (state_q == IDLE && instr_valid) begin
        instr_q <= instr;
        imm_q   <= imm;
      end
    end
  end

  // EXEC drives controls combinationally; the _q copies hold them afterwards.
  assign instr_ready = (state_q == IDLE);
  assign sel         = sel_d;
  assign wr          = wr_d & ~reset;
  assign op          = op_d;
  assign rd_addr_a   = rd_addr_a_d;
  assign rd_addr_b   = rd_addr_b_d;
  assign wr_addr     = wr_addr_d;
  assign d_in        = d_in_d;
  assign done        = (state_q == DONE);
  assign result      = result_q;
  assign flag        = flag_q;
  assign err         = err_q & done;

endmodule

// File: tb/tb_reg_alu_ctrl.sv
// Scoreboard bench for reg_alu_ctrl with a behavioural register file / ALU.
module tb_reg_alu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [15:0] imm = '0;
  logic        sel, wr, done, flag, err;
  logic [1:0]  op;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_in, rd_data, result;
  logic        cout_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  reg_alu_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm), .sel(sel), .wr(wr), .op(op),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in),
    .rd_data(rd_data), .cout_in(cout_in), .done(done), .result(result),
    .flag(flag), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath environment: 8x16 register file, ALU with registered carry.
  logic [15:0] regs [8];
  logic        cout_q = 1'b0;
  logic [16:0] alu_full;
  initial for (int i = 0; i < 8; i++) regs[i] = '0;
  always_comb begin
    case (op)
      2'd0: alu_full = {1'b0, regs[rd_addr_a]} + {1'b0, regs[rd_addr_b]};
      2'd1: alu_full = {1'b0, regs[rd_addr_a]} - {1'b0, regs[rd_addr_b]};
      2'd2: alu_full = {1'b0, regs[rd_addr_a] & regs[rd_addr_b]};
      default: alu_full = {1'b0, regs[rd_addr_a] | regs[rd_addr_b]};
    endcase
  end
  assign rd_data = regs[rd_addr_a];
  assign cout_in = cout_q;
  always @(posedge clk) begin
    if (wr) begin
      regs[wr_addr] <= sel ? alu_full[15:0] : d_in;
      if (sel) cout_q <= alu_full[16];
    end
  end

  typedef struct { logic [15:0] res; logic err; logic flag; int due; } dexp_t;
  typedef struct { logic [2:0] addr; logic sel; logic [15:0] d; logic [1:0] op;
                   logic [2:0] a; logic [2:0] b; } wexp_t;
  dexp_t dq[$];
  wexp_t wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] kind, input logic [1:0] o,
                                     input logic [2:0] dst, input logic [2:0] a,
                                     input logic [2:0] b);
    return {kind, o, dst, a, b, 3'b000};
  endfunction

  // Issue one instruction; the expected done and write events go to the scoreboard.
  task automatic issue(input logic [15:0] ins, input logic [15:0] im,
                       input logic [15:0] e_res, input logic e_err, input logic e_flag,
                       input int lat, input logic e_wr);
    int n = 0;
    dexp_t de;
    wexp_t we;
    @(negedge clk);
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) begin
      chk("ready_timeout", 32'(instr_ready), 32'd1);
      return;
    end
    instr = ins; imm = im; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 16'hDEAD; imm = 16'hBEEF;
    de.res = e_res; de.err = e_err; de.flag = e_flag; de.due = cyc + lat - 1;
    dq.push_back(de);
    if (e_wr) begin
      we.addr = ins[11:9]; we.sel = (ins[15:14] == 2'b10); we.d = im;
      we.op = ins[13:12]; we.a = ins[8:6]; we.b = ins[5:3];
      wq.push_back(we);
    end
    if (ins[15:14] == 2'b11) begin
      @(negedge clk);
      chk("rd_addr_a_exec", 32'(rd_addr_a), 32'(ins[8:6]));
    end
  endtask

  // Monitor: compares every done pulse and every write strobe against the queues.
  always @(negedge clk) begin
    dexp_t de;
    wexp_t we;
    if (done) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
      end else begin
        de = dq.pop_front();
        if (result !== de.res || err !== de.err || flag !== de.flag || cyc != de.due) begin
          errors++;
          $display("FAIL done_resp: got res=%h err=%b flag=%b cyc=%0d expected res=%h err=%b flag=%b cyc=%0d",
                   result, err, flag, cyc, de.res, de.err, de.flag, de.due);
        end
      end
    end
    if (wr) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got wr addr=%0d sel=%b expected no write", wr_addr, sel);
      end else begin
        we = wq.pop_front();
        if (wr_addr !== we.addr || sel !== we.sel ||
            (!we.sel && d_in !== we.d) ||
            (we.sel && (op !== we.op || rd_addr_a !== we.a || rd_addr_b !== we.b))) begin
          errors++;
          $display("FAIL wr_ctrl: got addr=%0d sel=%b d=%h op=%0d a=%0d b=%0d expected addr=%0d sel=%b d=%h op=%0d a=%0d b=%0d",
                   wr_addr, sel, d_in, op, rd_addr_a, rd_addr_b,
                   we.addr, we.sel, we.d, we.op, we.a, we.b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [1:0] K_NOP = 2'b00, K_LDI = 2'b01, K_ALU = 2'b10, K_RD = 2'b11;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_addrs", 32'({rd_addr_a, rd_addr_b, wr_addr}), 32'd0);
    chk("rst_d_in", 32'(d_in), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flag_err", 32'({flag, err}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    issue(mk(K_LDI, 0, 3, 0, 0), 16'h1234, 16'h0000, 0, 0, 2, 1);
    issue(mk(K_LDI, 0, 1, 0, 0), 16'hFFFF, 16'h0000, 0, 0, 2, 1);
    issue(mk(K_LDI, 0, 2, 0, 0), 16'h0001, 16'h0000, 0, 0, 2, 1);
    issue(mk(K_ALU, 0, 4, 1, 2), 16'h0000, 16'h0000, 0, 1, 3, 1);
    issue(mk(K_RD,  0, 0, 4, 0), 16'h0000, 16'h0000, 0, 1, 2, 0);
    issue(mk(K_LDI, 0, 4, 0, 0), 16'h5A5A, 16'h0000, 0, 1, 2, 1);
    issue(mk(K_RD,  0, 0, 4, 0), 16'h0000, 16'h5A5A, 0, 1, 2, 0);
    issue(16'h0001,              16'h0000, 16'h0000, 1, 1, 2, 0);
    issue(mk(K_ALU, 0, 5, 3, 3), 16'h0000, 16'h0000, 0, 0, 3, 1);
    issue(mk(K_RD,  0, 0, 5, 0), 16'h0000, 16'h2468, 0, 0, 2, 0);
    issue(mk(K_ALU, 0, 1, 1, 2), 16'h0000, 16'h0000, 0, 1, 3, 1);
    issue(mk(K_RD,  0, 0, 1, 0), 16'h0000, 16'h0000, 0, 1, 2, 0);
    issue(mk(K_LDI, 0, 6, 0, 0) | 16'h0004, 16'h7777, 16'h0000, 1, 1, 2, 0);
    issue(mk(K_RD,  0, 0, 6, 0), 16'h0000, 16'h0000, 0, 1, 2, 0);
    issue(mk(K_NOP, 0, 0, 0, 0), 16'h0000, 16'h0000, 0, 1, 2, 0);
`ifdef REG_ALU_CTRL_R0_ZERO_EN
    issue(mk(K_LDI, 0, 0, 0, 0), 16'hAAAA, 16'h0000, 1, 1, 2, 0);
    issue(mk(K_RD,  0, 0, 0, 0), 16'h0000, 16'h0000, 0, 1, 2, 0);
`else
    issue(mk(K_LDI, 0, 0, 0, 0), 16'hAAAA, 16'h0000, 0, 1, 2, 1);
    issue(mk(K_RD,  0, 0, 0, 0), 16'h0000, 16'hAAAA, 0, 1, 2, 0);
`endif

    // Reset asserted during the EXEC cycle of an ALU: no write, no done.
    @(negedge clk);
    while (!instr_ready) @(negedge clk);
    instr = mk(K_ALU, 0, 7, 1, 3); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rst_exec_wr", 32'(wr), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_exec_ready", 32'(instr_ready), 32'd1);
    chk("rst_exec_flag", 32'(flag), 32'd0);
    chk("rst_exec_done", 32'(done), 32'd0);
    repeat (4) @(negedge clk);

    issue(mk(K_LDI, 0, 7, 0, 0), 16'h0F0F, 16'h0000, 0, 0, 2, 1);
    issue(mk(K_RD,  0, 0, 7, 0), 16'h0000, 16'h0F0F, 0, 0, 2, 0);

    for (int i = 0; i < 20 && (dq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    chk("wr_queue_empty", 32'(wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
